mips_regfile: RTL and testbench

MIPS_REGFILE -- requirements
Module: mips_regfile

---
 rtl/mips_pkg.sv | 13 +
 rtl/mips_regfile_decoder5to32.sv | 27 ++
 rtl/mips_regfile.sv | 89 ++++++++
 tb/tb_mips_regfile.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS register file: geometry and the hard-wired zero index.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;

    // Index of the architectural $zero register.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage : mips_pkg

// File: rtl/mips_regfile_decoder5to32.sv
// Write-enable decoder: one-hot select of the destination register, all-zero when disabled.
// Latency: combinational.
// Backpressure: none; the output follows the inputs every cycle.
//
// Ports:
//   addr_i   - register index to select
//   en_i     - decode enable; when low the output is all zeros regardless of addr_i
//   onehot_o - one bit per register, at most one bit set
module decoder5to32 #(
    parameter int ADDR_W  = 5,
    parameter int NUM_OUT = 1 << ADDR_W
) (
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic               en_i,
    output logic [NUM_OUT-1:0] onehot_o
);

    // Gating on en_i first keeps an undriven/unknown addr_i from reaching the
    // register enables while no write is requested.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[addr_i] = 1'b1;
        end
    end

endmodule : decoder5to32

// File: rtl/mips_regfile.sv
// MIPS general-purpose register file: 2**ADDR_W x DATA_W, two combinational read ports, one write port.
// Latency: reads 0 cycles, writes visible after 1 rising edge (same cycle when REGFILE_BYPASS_EN forwards).
// Backpressure: none; a write is accepted every cycle reg_write is high.
//
// Build option: define REGFILE_BYPASS_EN to forward write_data to a read port whose
// index matches the in-flight write; otherwise reads return the pre-edge stored value.
//
// Ports:
//   clk        - single clock, all state updates on its rising edge
//   reset      - synchronous active-high reset, clears every register, wins over a write
//   reg_write  - write enable from the control unit
//   write_reg  - destination index (writes to index 0 are dropped)
//   write_data - write-back value from the MemtoReg mux
//   read_reg1  - rs index,  read_data1 - its contents
//   read_reg2  - rt index,  read_data2 - its contents
module mips_regfile #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    import mips_pkg::*;

    localparam int REG_CNT = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [REG_CNT-1:0] wr_en;
    logic               wr_req;
    logic [DATA_W-1:0]  regs_q [REG_CNT];
    logic [DATA_W-1:0]  regs_d [REG_CNT];

    // $zero is filtered before the decoder so its enable can never fire.
    assign wr_req = reg_write && (write_reg != ZERO_IDX);

    decoder5to32 #(
        .ADDR_W  (ADDR_W),
        .NUM_OUT (REG_CNT)
    ) u_wr_dec (
        .addr_i   (write_reg),
        .en_i     (wr_req),
        .onehot_o (wr_en)
    );

    always_comb begin
        for (int i = 0; i < REG_CNT; i++) begin
            regs_d[i] = wr_en[i] ? write_data : regs_q[i];
        end
    end

    // Reset is checked first so a coincident write is lost and the whole
    // array clears in one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Index 0 is forced to zero at the mux so it reads 0 even before the
    // first reset has initialised the storage.
    always_comb begin
        read_data1 = (read_reg1 == ZERO_IDX) ? '0 : regs_q[read_reg1];
        read_data2 = (read_reg2 == ZERO_IDX) ? '0 : regs_q[read_reg2];
`ifdef REGFILE_BYPASS_EN
        if (wr_req && (write_reg == read_reg1)) begin
            read_data1 = write_data;
        end
        if (wr_req && (write_reg == read_reg2)) begin
            read_data2 = write_data;
        end
`else
`endif
    end

endmodule : mips_regfile

// File: tb/tb_mips_regfile.sv
module tb_mips_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          reg_write = 1'b0;
    logic [AW-1:0] write_reg = '0;
    logic [DW-1:0] write_data = '0;
    logic [AW-1:0] read_reg1 = '0;
    logic [AW-1:0] read_reg2 = '0;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;

    always #5 clk = ~clk;

    mips_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    typedef struct {
        int            tag;
        bit            chk;
        logic [AW-1:0] idx1;
        logic [AW-1:0] idx2;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] model [NR];
    bit            model_valid = 1'b0;
    int            n_tests = 0;
    int            n_fail  = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Architectural view of a read: $zero is 0, an in-flight write is seen only
    // when forwarding is built in, otherwise the last committed value.
    function automatic logic [DW-1:0] arch_read(input logic [AW-1:0] idx, input bit we,
                                               input logic [AW-1:0] wr, input logic [DW-1:0] wd);
        if (idx == 0) return '0;
        if (BYPASS && we && wr == idx) return wd;
        return model[idx];
    endfunction

    // Apply one cycle of inputs; record the expected same-cycle reads, then
    // advance the model to the post-edge state.
    task automatic drive(input int tag, input bit rst, input bit we, input logic [AW-1:0] wr,
                         input logic [DW-1:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; reg_write = we; write_reg = wr; write_data = wd;
        read_reg1 = r1; read_reg2 = r2;
        e.tag = tag; e.idx1 = r1; e.idx2 = r2;
        // Before the first reset the stored contents are unknown; only index 0 is defined.
        e.chk  = model_valid || (r1 == 0 && r2 == 0);
        e.exp1 = arch_read(r1, we, wr, wd);
        e.exp2 = arch_read(r2, we, wr, wd);
        sb_q.push_back(e);
        if (rst) begin
            for (int i = 0; i < NR; i++) model[i] = '0;
            model_valid = 1'b1;
        end else if (we && wr != 0) begin
            model[wr] = wd;
        end
    endtask

    // Monitor: compare mid-cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.chk) begin
                    n_tests++;
                    if (read_data1 !== e.exp1) begin
                        n_fail++;
                        $display("FAIL rd1 tag=%0d idx=%0d got=%h exp=%h", e.tag, e.idx1, read_data1, e.exp1);
                    end
                    n_tests++;
                    if (read_data2 !== e.exp2) begin
                        n_fail++;
                        $display("FAIL rd2 tag=%0d idx=%0d got=%h exp=%h", e.tag, e.idx2, read_data2, e.exp2);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] wr, r1, r2;
        bit            we, rst;
        logic [DW-1:0] wd;
        for (int i = 0; i < NR; i++) model[i] = '0;

        // Index 0 reads zero even before any reset.
        drive(0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        // One-cycle reset, then sweep every index on both ports.
        drive(1, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < NR; i++) drive(2, 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(NR - 1 - i));
        // Write reg 8, read on both ports, reg 9 untouched.
        drive(3, 1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 5'd1, 5'd2);
        drive(3, 1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8);
        drive(3, 1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd8);
        // Write to $zero is dropped.
        drive(4, 1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        drive(4, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd8);
        // reg_write=0 leaves reg 5 alone.
        drive(5, 1'b0, 1'b1, 5'd5, 32'h0BADC0DE, 5'd5, 5'd0);
        drive(5, 1'b0, 1'b0, 5'd5, 32'hFFFFFFFF, 5'd5, 5'd5);
        drive(5, 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        // Reset beats a coincident write; all prior state cleared.
        drive(6, 1'b0, 1'b1, 5'd3, 32'h11111111, 5'd0, 5'd0);
        drive(6, 1'b1, 1'b1, 5'd3, 32'hAAAA5555, 5'd0, 5'd0);
        drive(6, 1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd8);
        drive(6, 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd3);
        // Same-cycle write/read of reg 31.
        drive(7, 1'b0, 1'b1, 5'd31, 32'h01010101, 5'd0, 5'd0);
        drive(7, 1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd31);
        drive(7, 1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);

        // Randomised traffic, reads biased toward the write index.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            we  = $urandom_range(0, 1) == 1;
            wr  = 5'($urandom_range(0, NR - 1));
            wd  = $urandom;
            r1  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, NR - 1));
            r2  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, NR - 1));
            drive(8, rst, we, wr, wd, r1, r2);
        end
        drive(9, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // Let the monitor drain, bounded.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got=%0d pending exp=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mips_regfile
